serial_slice_adder: RTL and testbench
=====================================

// Module: serial_slice_adder
// PURPOSE
//   Multi-cycle, parametrised add/subtract unit built from ripple full-adder cells.
//   Processes SLICE bits per clock from LSB to MSB and carries between slices in a register.
//   Sits between the operand registers and the result bus of the lab datapath.
//   Uses a start/busy/done handshake and returns C (carry), OVF (overflow) and ZERO flags.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be >= 2
//   SLICE  4   bits added per cycle; WIDTH % SLICE == 0 (elaboration error otherwise)
//   (derived) N = WIDTH/SLICE slice cycles per operation
// PORTS
//   clk    in   1      rising-edge clock; the only clock
//   rst_n  in   1      reset; synchronous, active-low
//   start  in   1      request; sampled only while idle
//   mode   in   1      0 = F = A+B, 1 = F = A-B; sampled with start
//   a      in   WIDTH  operand A; sampled with start
//   b      in   WIDTH  operand B; sampled with start
//   busy   out  1      high from the cycle after start is accepted until done
//   done   out  1      one-cycle pulse; result and flags valid from this cycle
//   f      out  WIDTH  result
//   c      out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf    out  1      two's-complement signed overflow
//   zero   out  1      f == 0
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge):
//   - state=IDLE; busy, done, f, c, ovf, zero = 0; slice counter = 0.
//   - Reset mid-operation aborts the operation. No done is issued and the partial result is discarded.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//   - IDLE: start=1 latches a, b^{WIDTH{mode}}, carry=mode, cnt=0; go to RUN.
//   - RUN: busy=1. Each cycle adds slice cnt (bits cnt*SLICE+:SLICE) through SLICE chained full-adder
//     cells (F = A^B^Cin, Cout = (A^B)&Cin | A&B) and writes the sum bits into the result shift register.
//     The carry register takes the slice carry-out. cnt++. After slice N-1, go to DONE.
//   - DONE: done=1 and busy=0 for exactly one cycle; f, c, ovf, zero update on entry; go to IDLE.
//   Latency and throughput:
//   - start sampled at edge T -> done high in cycle T+N+1.
//   - A new start is accepted at the earliest in the cycle after done, so throughput is one op per N+2 cycles.
//   Start handling: start while busy or during the done cycle is ignored and not queued.
//   Operands: a, b and mode may change freely after start is accepted; only the latched copies are used.
//   Outputs: f, c, ovf and zero hold their values until the next done; they do not change on start.
//   Flags:
//   - c = carry out of bit WIDTH-1.
//   - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//   - zero = ~|f.
//   Width rules:
//   - Arithmetic is modulo 2^WIDTH.
//   - SLICE == WIDTH is legal: N=1, done in cycle T+2.
//   - SLICE == 1 is legal: bit-serial, N=WIDTH.
// TESTING  (WIDTH=8, SLICE=2, N=4 unless stated)
//   add 0x7F+0x01, start at T -> busy T+1..T+4, done@T+5, f=0x80 c=0 ovf=1 zero=0
//   add 0xFF+0x01 -> f=0x00 c=1 ovf=0 zero=1; sub 0x05-0x05 -> f=0x00 c=1 ovf=0 zero=1
//   sub 0x80-0x01 -> f=0x7F c=1 ovf=1; sub 0x01-0x02 -> f=0xFF c=0 ovf=0 zero=0
//   start again at T+2 with a=0x00 and change a/b at T+2 -> ignored; done@T+5 carries original result
//   rst_n=0 at T+3 mid-run -> all outputs 0 at T+4, no done; next start completes normally
//   WIDTH=8, SLICE=8: 0x12+0x34 -> done@T+2, f=0x46; random 1000 ops vs a+b / a-b reference

Source files
------------

// File: rtl/serial_slice_adder.sv
// ---------------------------------------------------------------------------
// serial_slice_adder
//   Multi-cycle add/subtract unit. Each cycle it adds SLICE bits of the
//   operands, starting at the LSB, through a chain of full-adder cells. The
//   carry between slices is held in a register. One operation takes
//   N = WIDTH/SLICE slice cycles, followed by a one-cycle done pulse.
//   Subtraction is A + ~B + 1: B is inverted and the carry is preset when
//   the operands are latched.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      operation request, sampled only while idle
//   mode   in   1      0: f = a + b, 1: f = a - b (sampled with start)
//   a, b   in   WIDTH  operands (sampled with start)
//   busy   out  1      high while slices are being processed
//   done   out  1      one-cycle pulse, result and flags valid from here
//   f      out  WIDTH  result, held until the next done
//   c      out  1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  1      two's-complement signed overflow
//   zero   out  1      f == 0
// ---------------------------------------------------------------------------
module serial_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             c,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("serial_slice_adder: WIDTH must be >= 2 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_f;
  logic             r_c;
  logic             r_ovf;
  logic             r_zero;

  logic [SLICE:0]   w_cy;
  logic [SLICE-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == LAST);

  // Ripple chain for the current slice. The operand registers shift right
  // by SLICE each cycle, so the active slice always sits in the low bits.
  assign w_cy[0] = r_carry;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
    logic w_p;
    assign w_p          = r_a[gi] ^ r_b[gi];
    assign w_sum[gi]    = w_p ^ w_cy[gi];
    assign w_cy[gi + 1] = (w_p & w_cy[gi]) | (r_a[gi] & r_b[gi]);
  end

  // Result shift register: new sum bits enter at the top, so after N slices
  // the LSB slice has reached bit 0.
  always_comb begin
    w_res                      = r_sr >> SLICE;
    w_res[WIDTH-1 -: SLICE]    = w_sum;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand and partial-result registers; their contents are don't-care
  // until an operation is accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b ^ {WIDTH{mode}};
    end else if (w_run) begin
      r_a  <= r_a >> SLICE;
      r_b  <= r_b >> SLICE;
      r_sr <= w_res;
    end
  end

  // Slice carry, counter and the visible result/flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_f     <= '0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_carry <= mode;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_carry <= w_cy[SLICE];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        // Carry into the MSB is the carry into the top cell of the last slice.
        r_f    <= w_res;
        r_c    <= w_cy[SLICE];
        r_ovf  <= w_cy[SLICE] ^ w_cy[SLICE-1];
        r_zero <= ~|w_res;
      end
    end
  end

  assign f    = r_f;
  assign c    = r_c;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_serial_slice_adder.sv
module tb_serial_slice_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       st2 = 1'b0;
  logic       st8 = 1'b0;

  logic       busy2, done2, c2, ovf2, zero2;
  logic [7:0] f2;
  logic       busy8, done8, c8, ovf8, zero8;
  logic [7:0] f8;

  int tests = 0;
  int fails = 0;
  logic [7:0] prev_f [2];

  bit         sel = 1'b0;
  logic       m_busy, m_done, m_c, m_ovf, m_zero;
  logic [7:0] m_f;

  always #5 clk = ~clk;

  serial_slice_adder #(.WIDTH(8), .SLICE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .mode(mode), .a(a), .b(b),
    .busy(busy2), .done(done2), .f(f2), .c(c2), .ovf(ovf2), .zero(zero2)
  );

  serial_slice_adder #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .mode(mode), .a(a), .b(b),
    .busy(busy8), .done(done8), .f(f8), .c(c8), .ovf(ovf8), .zero(zero8)
  );

  assign m_busy = sel ? busy8 : busy2;
  assign m_done = sel ? done8 : done2;
  assign m_f    = sel ? f8    : f2;
  assign m_c    = sel ? c8    : c2;
  assign m_ovf  = sel ? ovf8  : ovf2;
  assign m_zero = sel ? zero8 : zero2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic on the operands.
  task automatic ref_model(input bit m, input logic [7:0] xa, input logic [7:0] xb,
                           output logic [7:0] ef, output logic ec,
                           output logic eo, output logic ez);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(xa);
    ub = int'(xb);
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    ur = m ? (ua - ub) : (ua + ub);
    sr = m ? (sa - sb) : (sa + sb);
    ef = ur[7:0];
    ec = m ? (ua >= ub) : (ur > 255);
    eo = (sr > 127) || (sr < -128);
    ez = (ef == 8'h00);
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) st8 = v;
    else   st2 = v;
  endtask

  // Called at posedge+1. Raises start so it is sampled at the next edge (T),
  // then checks busy/done timing and the result. With poke set, a second
  // start with changed operands is held from cycle T+2 through the done
  // cycle and must be ignored.
  task automatic run_op(input bit s, input bit m, input logic [7:0] xa,
                        input logic [7:0] xb, input bit poke);
    int n;
    logic [7:0] ef;
    logic ec, eo, ez;
    n = s ? 1 : 4;
    sel = s;
    ref_model(m, xa, xb, ef, ec, eo, ez);
    mode = m; a = xa; b = xb;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    mode = ~m; a = 8'($urandom); b = 8'($urandom);
    chk("busy_first", m_busy, 1'b1);
    chk("done_first", m_done, 1'b0);
    chk("f_hold", m_f, prev_f[s]);
    if (poke && n > 1) begin
      set_start(s, 1'b1);
      a = 8'h00; b = 8'h00;
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k < n) begin
        chk("busy_run", m_busy, 1'b1);
        chk("done_run", m_done, 1'b0);
      end else begin
        chk("done", m_done, 1'b1);
        chk("busy_done", m_busy, 1'b0);
        chk("f", m_f, ef);
        chk("c", m_c, ec);
        chk("ovf", m_ovf, eo);
        chk("zero", m_zero, ez);
      end
    end
    @(posedge clk); #1;
    set_start(s, 1'b0);
    chk("done_after", m_done, 1'b0);
    chk("busy_after", m_busy, 1'b0);
    prev_f[s] = ef;
  endtask

  initial begin
    prev_f[0] = 8'h00;
    prev_f[1] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_done2", done2, 1'b0);
    chk("rst_f2", f2, 8'h00);
    chk("rst_flags2", {c2, ovf2, zero2}, 3'b000);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_f8", f8, 8'h00);
    chk("rst_flags8", {c8, ovf8, zero8}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, WIDTH=8 SLICE=2
    run_op(1'b0, 1'b0, 8'h7F, 8'h01, 1'b0);
    run_op(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0);
    run_op(1'b0, 1'b1, 8'h05, 8'h05, 1'b0);
    run_op(1'b0, 1'b1, 8'h80, 8'h01, 1'b0);
    run_op(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    // Start while busy and during done, with changed operands: ignored
    run_op(1'b0, 1'b0, 8'h3C, 8'h5A, 1'b1);

    // Reset mid-run
    sel = 1'b0;
    mode = 1'b0; a = 8'h7F; b = 8'h01;
    st2 = 1'b1;
    @(posedge clk); #1;          // edge T accepts
    st2 = 1'b0;
    @(posedge clk); #1;          // T+1
    @(posedge clk); #1;          // T+2
    rst_n = 1'b0;
    @(posedge clk); #1;          // T+3 reset edge
    chk("midrst_busy", busy2, 1'b0);
    chk("midrst_done", done2, 1'b0);
    chk("midrst_f", f2, 8'h00);
    chk("midrst_flags", {c2, ovf2, zero2}, 3'b000);
    rst_n = 1'b1;
    prev_f[0] = 8'h00;
    prev_f[1] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("midrst_nodone", done2, 1'b0);
    end
    run_op(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);

    // WIDTH=8 SLICE=8: done two cycles after start
    run_op(1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
    run_op(1'b1, 1'b1, 8'h80, 8'h01, 1'b0);
    run_op(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0);

    // Random operations
    for (int i = 0; i < 1000; i++) begin
      run_op(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 200; i++) begin
      run_op(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
